// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and types for the multiport register file
//                (default width, depth and read-port count; address and data
//                word types).
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage
`default_nettype wire

// File: rtl/multiport_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_register_file_if
//  Description : Decode/writeback bus of the register file.
//                master (decode/writeback side) drives:
//                  RegWrite, rd, in        writeback port
//                  rs                      packed read indices, ADDR_W each
//                  issue_en, issue_rd      destination issue
//                slave (register file) drives:
//                  out                     packed read data, DATA_W each
//                  rs_busy, hazard         operand-pending flags
//  Revision    : 1.0  initial release
// ============================================================================
interface multiport_register_file_if #(
   parameter int DATA_W = rf_pkg::RF_DATA_W,
   parameter int ADDR_W = rf_pkg::RF_ADDR_W,
   parameter int NUM_RD = rf_pkg::RF_NUM_RD
);
   logic                     RegWrite;
   logic [ADDR_W-1:0]        rd;
   logic [DATA_W-1:0]        in;
   logic [NUM_RD*ADDR_W-1:0] rs;
   logic [NUM_RD*DATA_W-1:0] out;
   logic                     issue_en;
   logic [ADDR_W-1:0]        issue_rd;
   logic [NUM_RD-1:0]        rs_busy;
   logic                     hazard;

   modport master (
      output RegWrite, rd, in, rs, issue_en, issue_rd,
      input  out, rs_busy, hazard
   );

   modport slave (
      input  RegWrite, rd, in, rs, issue_en, issue_rd,
      output out, rs_busy, hazard
   );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : One busy bit per register. Issue sets, writeback retires,
//                and each read port reports whether its operand is still
//                outstanding.
//  Ports       : clk, rst_n           clock, async active-low reset
//                wr_en, wr_rd         writeback (retire) strobe and index
//                issue_en, issue_rd   issue strobe and destination
//                rs                   packed read indices
//                rs_busy, hazard      per-port pending flags and their OR
//  Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard #(
   parameter int ADDR_W   = rf_pkg::RF_ADDR_W,
   parameter int NUM_RD   = rf_pkg::RF_NUM_RD,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   input  wire logic                     wr_en,
   input  wire logic [ADDR_W-1:0]        wr_rd,
   input  wire logic                     issue_en,
   input  wire logic [ADDR_W-1:0]        issue_rd,
   input  wire logic [NUM_RD*ADDR_W-1:0] rs,
   output logic      [NUM_RD-1:0]        rs_busy,
   output logic                          hazard
);

   localparam int c_depth = 2**ADDR_W;

   logic [c_depth-1:0] r_busy;
   logic [c_depth-1:0] w_busy_next;
   logic               w_issue_ok;
   logic [NUM_RD-1:0]  w_rs_busy;

   // Register 0 never becomes a producer when it is hardwired.
   assign w_issue_ok = issue_en && !(ZERO_REG && (issue_rd == '0));

   // Retire first, then set: a same-cycle issue of the retiring register
   // means a newer producer is now outstanding.
   always_comb begin
      w_busy_next = r_busy;
      if (wr_en) begin
         w_busy_next[wr_rd] = 1'b0;
      end
      if (w_issue_ok) begin
         w_busy_next[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      logic [ADDR_W-1:0] w_rs;
      logic              w_fwd;
      assign w_rs  = rs[i*ADDR_W +: ADDR_W];
      // An operand arriving this cycle through the bypass is not pending.
      assign w_fwd = BYPASS && wr_en && (wr_rd == w_rs);
      assign w_rs_busy[i] = rst_n && r_busy[w_rs] && !w_fwd;
   end

   assign rs_busy = w_rs_busy;
   assign hazard  = |w_rs_busy;

endmodule
`default_nettype wire

// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_register_file
//  Description : Parametrised register file with NUM_RD combinational read
//                ports, one write port, optional write-to-read bypass,
//                optional hardwired zero register and a busy scoreboard.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    multiport_register_file_if.slave (write, read,
//                       issue and hazard signals)
//  Revision    : 1.0  initial release
// ============================================================================
module multiport_register_file
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input wire logic                 clk,
   input wire logic                 rst_n,
   multiport_register_file_if.slave bus
);

   localparam int c_depth = 2**ADDR_W;

   logic [DATA_W-1:0]        r_mem [c_depth];
   logic                     w_wr_en;
   logic [NUM_RD*DATA_W-1:0] w_out;

   // Writes to a hardwired zero register are dropped.
   assign w_wr_en = bus.RegWrite && !(ZERO_REG && (bus.rd == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < c_depth; r++) begin
            r_mem[r] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[bus.rd] <= bus.in;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_rs;
      logic [DATA_W-1:0] w_data;
      assign w_rs = bus.rs[i*ADDR_W +: ADDR_W];
      // Priority, lowest to highest: stored value, bypass, zero register,
      // reset. Reset gating keeps the bypass path from leaking data while
      // rst_n is low.
      always_comb begin
         w_data = r_mem[w_rs];
         if (BYPASS && bus.RegWrite && (bus.rd == w_rs)) begin
            w_data = bus.in;
         end
         if (ZERO_REG && (w_rs == '0)) begin
            w_data = '0;
         end
         if (!rst_n) begin
            w_data = '0;
         end
      end
      assign w_out[i*DATA_W +: DATA_W] = w_data;
   end

   assign bus.out = w_out;

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (bus.RegWrite),
      .wr_rd    (bus.rd),
      .issue_en (bus.issue_en),
      .issue_rd (bus.issue_rd),
      .rs       (bus.rs),
      .rs_busy  (bus.rs_busy),
      .hazard   (bus.hazard)
   );

endmodule
`default_nettype wire
